vp_frame_ctrl: RTL and testbench

//  Frame-level sequencer for the HDMI video-processing path. Sits directly after the hdmi_in

---
 rtl/vp_pkg.sv | 21 ++
 rtl/vp_edge_det.sv | 36 +++
 rtl/vp_frame_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_vp_frame_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vp_pkg
// Brief    : Shared video-path types and default frame geometry.
// Revision : 1.0
// ============================================================================
package vp_pkg;

  localparam int unsigned C_H_RES       = 64;
  localparam int unsigned C_V_RES       = 64;
  localparam int unsigned C_CW          = 11;
  localparam int unsigned C_FRAME_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_ACTIVE = 2'd2
  } vp_state_e;

endpackage
`default_nettype wire

// File: rtl/vp_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : vp_edge_det
// Brief    : Registers a sync/enable input (polarity-normalised), flags its edges.
// Revision : 1.0
// ============================================================================
module vp_edge_det #(
  parameter bit POL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;
  logic r_q_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= 1'b0;
      r_q_d <= 1'b0;
    end else begin
      r_q   <= (i_sig == POL);
      r_q_d <= r_q;
    end
  end

  assign o_level = r_q;
  assign o_rise  = r_q & ~r_q_d;
  assign o_fall  = ~r_q & r_q_d;

endmodule
`default_nettype wire

// File: rtl/vp_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vp_frame_ctrl
// Brief    : Whole-frame gating, pixel coordinates, strobes and geometry check.
// Revision : 1.0
// ============================================================================
module vp_frame_ctrl
  import vp_pkg::*;
#(
  parameter int unsigned H_RES    = C_H_RES,
  parameter int unsigned V_RES    = C_V_RES,
  parameter int unsigned CW       = C_CW,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          de_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          run_req,
  input  logic          err_clr,
  output logic          proc_en,
  output logic          de_out,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          sof,
  output logic          eol,
  output logic          eof,
  output logic          frame_err,
  output logic          err_flag,
  output logic [7:0]    frame_cnt
);

  localparam logic [CW-1:0] C_X_LAST  = CW'(H_RES - 1);
  localparam logic [CW-1:0] C_Y_LAST  = CW'(V_RES - 1);
  localparam logic [CW-1:0] C_Y_COUNT = CW'(V_RES);

  vp_state_e     r_state;
  vp_state_e     w_state_nxt;
  logic          w_active;
  logic          w_close;
  logic          w_enter;

  logic          w_de_q;
  logic          w_de_rise;
  logic          w_de_fall;
  logic          w_vs_q;
  logic          w_vs_rise;
  logic          w_vs_fall;
  logic          w_line_end;
  logic          w_count_err;
  logic          w_unused;

  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_first;
  logic          r_line_err;
  logic          r_frame_err;
  logic          r_err_flag;
  logic [7:0]    r_frame_cnt;

  vp_edge_det #(
    .POL (1'b1)
  ) u_de_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_sig   (de_in),
    .o_level (w_de_q),
    .o_rise  (w_de_rise),
    .o_fall  (w_de_fall)
  );

  vp_edge_det #(
    .POL (SYNC_POL)
  ) u_vs_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_sig   (vs_in),
    .o_level (w_vs_q),
    .o_rise  (w_vs_rise),
    .o_fall  (w_vs_fall)
  );

  // hs is kept on the port for debug alignment only
  assign w_unused = &{1'b0, hs_in, w_de_rise, w_de_fall, w_vs_q, w_vs_fall};

  // Registered de is the current pixel; raw de_in low means it is the last one
  assign w_line_end = w_de_q & ~de_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_active    = 1'b0;
    w_close     = 1'b0;
    w_enter     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run_req) begin
          w_state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        if (!run_req) begin
          w_state_nxt = ST_IDLE;
        end else if (w_vs_rise) begin
          w_state_nxt = ST_ACTIVE;
          w_enter     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        w_active = 1'b1;
        if (w_vs_rise) begin
          w_close = 1'b1;
          if (!run_req) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      if (!w_de_q) begin
        r_x <= '0;
      end else if (r_x != '1) begin
        r_x <= r_x + CW'(1);
      end

      if (w_vs_rise) begin
        r_y <= '0;
      end else if (w_line_end && (r_y != '1)) begin
        r_y <= r_y + CW'(1);
      end
    end
  end

  // The line-count check is waived for the first frame after arming
  assign w_count_err = ~r_first & (r_y != C_Y_COUNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_first     <= 1'b0;
      r_line_err  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_flag  <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_frame_err <= w_close & (r_line_err | w_count_err);
      r_err_flag  <= r_frame_err | (r_err_flag & ~err_clr);

      if (w_close) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end

      if (w_enter) begin
        r_first <= 1'b1;
      end else if (w_close) begin
        r_first <= 1'b0;
      end

      if (w_vs_rise) begin
        r_line_err <= 1'b0;
      end else if (w_active && w_line_end && (r_x != C_X_LAST)) begin
        r_line_err <= 1'b1;
      end
    end
  end

  assign proc_en   = w_active;
  assign de_out    = w_de_q & w_active;
  assign x         = r_x;
  assign y         = r_y;
  assign sof       = de_out & (r_x == '0) & (r_y == '0);
  assign eol       = de_out & ~de_in;
  assign eof       = eol & (r_y == C_Y_LAST);
  assign frame_err = r_frame_err;
  assign err_flag  = r_err_flag;
  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vp_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vp_frame_ctrl
// Brief    : Directed self-checking bench for vp_frame_ctrl (64x64 frames).
// Revision : 1.0
// ============================================================================
module tb_vp_frame_ctrl;

  localparam int unsigned H_RES = 64;
  localparam int unsigned V_RES = 64;
  localparam int unsigned CW    = 11;
  localparam int          HB    = 2;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          de_in   = 1'b0;
  logic          hs_in   = 1'b0;
  logic          vs_in   = 1'b0;
  logic          run_req = 1'b0;
  logic          err_clr = 1'b0;
  logic          proc_en;
  logic          de_out;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          sof;
  logic          eol;
  logic          eof;
  logic          frame_err;
  logic          err_flag;
  logic [7:0]    frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int            mon_sof  = 0;
  int            mon_eof  = 0;
  int            mon_eol  = 0;
  int            mon_ferr = 0;
  int            mon_deo  = 0;
  logic [CW-1:0] sof_x = '0;
  logic [CW-1:0] sof_y = '0;
  logic [CW-1:0] eof_x = '0;
  logic [CW-1:0] eof_y = '0;

  vp_frame_ctrl #(
    .H_RES    (H_RES),
    .V_RES    (V_RES),
    .CW       (CW),
    .SYNC_POL (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .de_in     (de_in),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .run_req   (run_req),
    .err_clr   (err_clr),
    .proc_en   (proc_en),
    .de_out    (de_out),
    .x         (x),
    .y         (y),
    .sof       (sof),
    .eol       (eol),
    .eof       (eof),
    .frame_err (frame_err),
    .err_flag  (err_flag),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Strobe recorder, sampled mid-cycle once inputs for the cycle are settled
  always @(negedge clk) begin
    if (sof) begin
      mon_sof = mon_sof + 1;
      sof_x   = x;
      sof_y   = y;
    end
    if (eof) begin
      mon_eof = mon_eof + 1;
      eof_x   = x;
      eof_y   = y;
    end
    if (eol)       mon_eol  = mon_eol + 1;
    if (frame_err) mon_ferr = mon_ferr + 1;
    if (de_out)    mon_deo  = mon_deo + 1;
  end

  task automatic cyc(input logic d, input logic v);
    de_in = d;
    vs_in = v;
    hs_in = ~d & ~v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int len);
    for (int i = 0; i < len; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < HB; i++)  cyc(1'b0, 1'b0);
  endtask

  task automatic send_lines(input int n, input int bad_y, input int bad_len);
    for (int l = 0; l < n; l++) send_line((l == bad_y) ? bad_len : int'(H_RES));
  endtask

  task automatic vs_pulse();
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    run_req = 1'b0;
    err_clr = 1'b0;
    repeat (3) cyc(1'b0, 1'b0);
    n_checks++;
    if ({proc_en, de_out, sof, eol, eof, frame_err, err_flag} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {proc_en, de_out, sof, eol, eof, frame_err, err_flag});
    end
    n_checks++;
    if (x !== 11'd0 || y !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_xy: got x=%0d y=%0d expected 0,0", x, y);
    end
    n_checks++;
    if (frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt);
    end
    rst_n = 1'b1;
    cyc(1'b0, 1'b0);
    n_checks++;
    if (proc_en !== 1'b0 || frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL post_reset: got proc_en=%b frame_cnt=%0d expected 0,0", proc_en, frame_cnt);
    end
  endtask

  task automatic test_idle();
    int deo0, sof0;
    deo0 = mon_deo;
    sof0 = mon_sof;
    for (int f = 0; f < 3; f++) begin
      vs_pulse();
      send_lines(V_RES, -1, 0);
    end
    vs_pulse();
    n_checks++;
    if (proc_en !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_proc_en: got %b expected 0", proc_en);
    end
    n_checks++;
    if (mon_deo - deo0 !== 0) begin
      n_fail++;
      $display("FAIL idle_de_out: got %0d de_out cycles expected 0", mon_deo - deo0);
    end
    n_checks++;
    if (mon_sof - sof0 !== 0 || frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL idle_frames: got sof=%0d frame_cnt=%0d expected 0,0", mon_sof - sof0, frame_cnt);
    end
  endtask

  task automatic test_start_mid_frame();
    int sof0, eof0, eol0, deo0, ferr0;
    vs_pulse();
    send_lines(30, -1, 0);
    run_req = 1'b1;
    sof0    = mon_sof;
    deo0    = mon_deo;
    send_lines(V_RES - 30, -1, 0);
    n_checks++;
    if (proc_en !== 1'b0 || mon_deo - deo0 !== 0 || mon_sof - sof0 !== 0) begin
      n_fail++;
      $display("FAIL arm_gating: got proc_en=%b de_out=%0d sof=%0d expected 0,0,0",
               proc_en, mon_deo - deo0, mon_sof - sof0);
    end
    vs_pulse();
    n_checks++;
    if (proc_en !== 1'b1) begin
      n_fail++;
      $display("FAIL arm_proc_en: got %b expected 1 after vs", proc_en);
    end
    sof0  = mon_sof;
    eof0  = mon_eof;
    eol0  = mon_eol;
    deo0  = mon_deo;
    ferr0 = mon_ferr;
    send_lines(V_RES, -1, 0);
    vs_pulse();
    n_checks++;
    if (mon_sof - sof0 !== 1 || sof_x !== 11'd0 || sof_y !== 11'd0) begin
      n_fail++;
      $display("FAIL first_sof: got n=%0d x=%0d y=%0d expected 1,0,0", mon_sof - sof0, sof_x, sof_y);
    end
    n_checks++;
    if (mon_eof - eof0 !== 1 || eof_x !== 11'd63 || eof_y !== 11'd63) begin
      n_fail++;
      $display("FAIL first_eof: got n=%0d x=%0d y=%0d expected 1,63,63", mon_eof - eof0, eof_x, eof_y);
    end
    n_checks++;
    if (mon_eol - eol0 !== 64) begin
      n_fail++;
      $display("FAIL first_eol: got %0d expected 64", mon_eol - eol0);
    end
    n_checks++;
    if (mon_deo - deo0 !== 4096) begin
      n_fail++;
      $display("FAIL first_de_out: got %0d expected 4096", mon_deo - deo0);
    end
    n_checks++;
    if (frame_cnt !== 8'd1 || mon_ferr - ferr0 !== 0) begin
      n_fail++;
      $display("FAIL first_close: got frame_cnt=%0d frame_err=%0d expected 1,0", frame_cnt, mon_ferr - ferr0);
    end
  endtask

  task automatic test_stop();
    int eof0, ferr0, deo0;
    eof0  = mon_eof;
    ferr0 = mon_ferr;
    send_lines(20, -1, 0);
    run_req = 1'b0;
    send_lines(V_RES - 20, -1, 0);
    n_checks++;
    if (proc_en !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_in_frame: got proc_en=%b expected 1", proc_en);
    end
    vs_pulse();
    n_checks++;
    if (mon_eof - eof0 !== 1 || mon_ferr - ferr0 !== 0) begin
      n_fail++;
      $display("FAIL stop_eof: got eof=%0d frame_err=%0d expected 1,0", mon_eof - eof0, mon_ferr - ferr0);
    end
    n_checks++;
    if (proc_en !== 1'b0 || frame_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL stop_close: got proc_en=%b frame_cnt=%0d expected 0,2", proc_en, frame_cnt);
    end
    deo0 = mon_deo;
    send_lines(V_RES, -1, 0);
    vs_pulse();
    n_checks++;
    if (frame_cnt !== 8'd2 || mon_deo - deo0 !== 0) begin
      n_fail++;
      $display("FAIL stop_hold: got frame_cnt=%0d de_out=%0d expected 2,0", frame_cnt, mon_deo - deo0);
    end
  endtask

  task automatic test_short_line();
    int ferr0;
    run_req = 1'b1;
    cyc(1'b0, 1'b0);
    vs_pulse();
    ferr0 = mon_ferr;
    send_lines(V_RES, 10, 63);
    n_checks++;
    if (err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL short_pre_flag: got %b expected 0", err_flag);
    end
    vs_pulse();
    n_checks++;
    if (mon_ferr - ferr0 !== 1) begin
      n_fail++;
      $display("FAIL short_frame_err: got %0d pulses expected 1", mon_ferr - ferr0);
    end
    n_checks++;
    if (err_flag !== 1'b1 || frame_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL short_flag: got err_flag=%b frame_cnt=%0d expected 1,3", err_flag, frame_cnt);
    end
    err_clr = 1'b1;
    cyc(1'b0, 1'b0);
    err_clr = 1'b0;
    cyc(1'b0, 1'b0);
    n_checks++;
    if (err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL short_clear: got err_flag=%b expected 0", err_flag);
    end
  endtask

  task automatic test_short_frame();
    int ferr0;
    ferr0 = mon_ferr;
    send_lines(V_RES - 1, -1, 0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    n_checks++;
    if (frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL lines63_frame_err: got %b expected 1", frame_err);
    end
    err_clr = 1'b1;
    cyc(1'b0, 1'b0);
    err_clr = 1'b0;
    cyc(1'b0, 1'b0);
    n_checks++;
    if (err_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins: got err_flag=%b expected 1", err_flag);
    end
    n_checks++;
    if (mon_ferr - ferr0 !== 1 || frame_cnt !== 8'd4) begin
      n_fail++;
      $display("FAIL lines63_close: got frame_err=%0d frame_cnt=%0d expected 1,4", mon_ferr - ferr0, frame_cnt);
    end
  endtask

  task automatic test_abort_and_wrap();
    int eof0, ferr0;
    eof0  = mon_eof;
    ferr0 = mon_ferr;
    send_lines(30, -1, 0);
    for (int i = 0; i < 31; i++) cyc(1'b1, 1'b0);
    n_checks++;
    if (x !== 11'd30 || y !== 11'd30 || de_out !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_position: got x=%0d y=%0d de_out=%b expected 30,30,1", x, y, de_out);
    end
    rst_n = 1'b0;
    cyc(1'b1, 1'b0);
    n_checks++;
    if ({proc_en, de_out, sof, eol, eof, frame_err, err_flag} !== 7'b0) begin
      n_fail++;
      $display("FAIL abort_flags: got %b expected 0000000",
               {proc_en, de_out, sof, eol, eof, frame_err, err_flag});
    end
    n_checks++;
    if (x !== 11'd0 || y !== 11'd0 || frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_counters: got x=%0d y=%0d frame_cnt=%0d expected 0,0,0", x, y, frame_cnt);
    end
    cyc(1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    n_checks++;
    if (mon_eof - eof0 !== 0 || mon_ferr - ferr0 !== 0) begin
      n_fail++;
      $display("FAIL abort_no_close: got eof=%0d frame_err=%0d expected 0,0", mon_eof - eof0, mon_ferr - ferr0);
    end
    cyc(1'b0, 1'b0);
    vs_pulse();
    for (int f = 1; f < 256; f++) begin
      send_line(4);
      vs_pulse();
    end
    n_checks++;
    if (frame_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL wrap_255: got %0d expected 255", frame_cnt);
    end
    send_line(4);
    vs_pulse();
    n_checks++;
    if (frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_0: got %0d expected 0", frame_cnt);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_idle();
    test_start_mid_frame();
    test_stop();
    test_short_line();
    test_short_frame();
    test_abort_and_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
